// File: rtl/combo_lock_pkg.sv
// Shared types and defaults for the combination-lock controller.
// Holds the FSM state enum, default digit geometry and the reset code.
package combo_lock_pkg;

    typedef enum logic [2:0] {
        LOCKED,
        CHECK,
        FAIL,
        LOCKOUT,
        UNLOCKED,
        PROGRAM
    } state_t;

    localparam int DIGIT_W_DEF    = 4;
    localparam int NUM_DIGITS_DEF = 4;
    localparam logic [DIGIT_W_DEF*NUM_DIGITS_DEF-1:0] DEFAULT_CODE_DEF = 16'h1234;

endpackage

// File: rtl/combo_digit_counter.sv
// Modulo-N digit counter for keypad entry; clr has priority over inc.
// Ports: clk, rst, inc, clr in; count out, wrap pulses on the N-th inc.
module combo_digit_counter #(
    parameter int N  = 4,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          wrap
);

    assign wrap = inc && !clr && (count == CW'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/combo_lock_ctrl.sv
// Combination-lock sequencer: digit entry, code compare, fail/lockout, reprogram.
// Ports: clk, rst, digit_valid, digit, clear, relock, prog in;
//        unlocked, fail, locked_out, digit_cnt, prog_active out.
// Optional feature: define COMBO_LOCKOUT_EN to enable the fail-count lockout.
module combo_lock_ctrl
    import combo_lock_pkg::*;
#(
    parameter int DIGIT_W        = DIGIT_W_DEF,
    parameter int NUM_DIGITS     = NUM_DIGITS_DEF,
    parameter logic [DIGIT_W*NUM_DIGITS-1:0] DEFAULT_CODE = DEFAULT_CODE_DEF,
    parameter int FAIL_CYCLES    = 8,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 1024
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              digit_valid,
    input  logic [DIGIT_W-1:0]                digit,
    input  logic                              clear,
    input  logic                              relock,
    input  logic                              prog,
    output logic                              unlocked,
    output logic                              fail,
    output logic                              locked_out,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_cnt,
    output logic                              prog_active
);

    localparam int EW   = DIGIT_W * NUM_DIGITS;
    localparam int CW   = $clog2(NUM_DIGITS + 1);
    localparam int TMAX = (FAIL_CYCLES > LOCKOUT_CYCLES) ? FAIL_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    state_t          state;
    logic [EW-1:0]   entry;
    logic [EW-1:0]   code;
    logic [EW-1:0]   shifted;
    logic [TW-1:0]   timer;
    logic            entering;
    logic            abort;
    logic            cnt_inc;
    logic            cnt_clr;
    logic            last;

    // Counter only runs while collecting digits; any abort zeroes it.
    always_comb begin
        entering = (state == LOCKED) || (state == PROGRAM);
        abort    = ((state == LOCKED) && clear) ||
                   ((state == PROGRAM) && (clear || relock));
        cnt_inc  = entering && digit_valid;
        cnt_clr  = !entering || abort;
        shifted  = {entry[EW-DIGIT_W-1:0], digit};
    end

    combo_digit_counter #(
        .N  (NUM_DIGITS),
        .CW (CW)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (cnt_inc),
        .clr   (cnt_clr),
        .count (digit_cnt),
        .wrap  (last)
    );

`ifdef COMBO_LOCKOUT_EN
    localparam int FW = $clog2(MAX_FAILS + 1);
    logic [FW-1:0] fcnt;
`else
    assign locked_out = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= LOCKED;
            code        <= DEFAULT_CODE;
            entry       <= '0;
            timer       <= '0;
            unlocked    <= 1'b0;
            fail        <= 1'b0;
            prog_active <= 1'b0;
`ifdef COMBO_LOCKOUT_EN
            locked_out  <= 1'b0;
            fcnt        <= '0;
`endif
        end else begin
            unique case (state)
                LOCKED: begin
                    if (clear) begin
                        entry <= '0;
                    end else if (digit_valid) begin
                        entry <= shifted;
                        if (last) state <= CHECK;
                    end
                end
                CHECK: begin
                    if (entry == code) begin
                        state    <= UNLOCKED;
                        unlocked <= 1'b1;
`ifdef COMBO_LOCKOUT_EN
                        fcnt     <= '0;
`endif
                    end else begin
                        state <= FAIL;
                        fail  <= 1'b1;
                        timer <= TW'(FAIL_CYCLES - 1);
`ifdef COMBO_LOCKOUT_EN
                        if (fcnt != FW'(MAX_FAILS)) fcnt <= fcnt + 1'b1;
`endif
                    end
                end
                FAIL: begin
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else begin
                        fail  <= 1'b0;
                        entry <= '0;
`ifdef COMBO_LOCKOUT_EN
                        if (fcnt == FW'(MAX_FAILS)) begin
                            state      <= LOCKOUT;
                            locked_out <= 1'b1;
                            timer      <= TW'(LOCKOUT_CYCLES - 1);
                        end else begin
                            state <= LOCKED;
                        end
`else
                        state <= LOCKED;
`endif
                    end
                end
`ifdef COMBO_LOCKOUT_EN
                LOCKOUT: begin
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else begin
                        state      <= LOCKED;
                        locked_out <= 1'b0;
                        fcnt       <= '0;
                    end
                end
`endif
                UNLOCKED: begin
                    if (relock) begin
                        state    <= LOCKED;
                        unlocked <= 1'b0;
                        entry    <= '0;
                    end else if (prog) begin
                        state       <= PROGRAM;
                        prog_active <= 1'b1;
                        entry       <= '0;
                    end
                end
                PROGRAM: begin
                    if (relock) begin
                        state       <= LOCKED;
                        unlocked    <= 1'b0;
                        prog_active <= 1'b0;
                        entry       <= '0;
                    end else if (clear) begin
                        state       <= UNLOCKED;
                        prog_active <= 1'b0;
                        entry       <= '0;
                    end else if (digit_valid) begin
                        entry <= shifted;
                        if (last) begin
                            code        <= shifted;
                            state       <= UNLOCKED;
                            prog_active <= 1'b0;
                            entry       <= '0;
                        end
                    end
                end
                default: state <= LOCKED;
            endcase
        end
    end

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Directed self-checking bench for combo_lock_ctrl.
// Covers unlock, fail timing, clear priority, reprogram, reset and lockout.
module tb_combo_lock_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       digit_valid;
    logic [3:0] digit;
    logic       clear;
    logic       relock;
    logic       prog;
    logic       unlocked;
    logic       fail;
    logic       locked_out;
    logic [2:0] digit_cnt;
    logic       prog_active;

    int n_checks = 0;
    int n_fails  = 0;

    combo_lock_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .digit_valid (digit_valid),
        .digit       (digit),
        .clear       (clear),
        .relock      (relock),
        .prog        (prog),
        .unlocked    (unlocked),
        .fail        (fail),
        .locked_out  (locked_out),
        .digit_cnt   (digit_cnt),
        .prog_active (prog_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [3:0] d);
        digit_valid = 1'b1;
        digit       = d;
        step();
        digit_valid = 1'b0;
    endtask

    task automatic enter4(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
        strobe(a);
        strobe(b);
        strobe(c);
        strobe(d);
    endtask

    // Counts cycles with fail high, optionally strobing digits meanwhile.
    task automatic wait_fail(input logic junk, output int n);
        n = 0;
        while (fail === 1'b1 && n < 100) begin
            digit_valid = junk;
            digit       = 4'h1;
            step();
            n++;
        end
        digit_valid = 1'b0;
    endtask

    int n;
    int m;
    int seen_unlock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        digit_valid = 1'b0;
        digit = 4'h0;
        clear = 1'b0;
        relock = 1'b0;
        prog = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        step();

        chk("rst_unlocked", unlocked, 0);
        chk("rst_fail", fail, 0);
        chk("rst_lockout", locked_out, 0);
        chk("rst_cnt", digit_cnt, 0);
        chk("rst_prog", prog_active, 0);

        // Correct code, back-to-back strobes.
        strobe(4'h1);
        chk("cnt1", digit_cnt, 1);
        strobe(4'h2);
        chk("cnt2", digit_cnt, 2);
        strobe(4'h3);
        chk("cnt3", digit_cnt, 3);
        strobe(4'h4);
        chk("cnt_wrap", digit_cnt, 0);
        chk("check_not_yet", unlocked, 0);
        step();
        chk("unlock_ok", unlocked, 1);
        chk("unlock_nofail", fail, 0);
        relock = 1'b1;
        step();
        relock = 1'b0;
        chk("relock", unlocked, 0);

        // Wrong code: fail for 8 cycles, strobes ignored meanwhile.
        enter4(4'h1, 4'h2, 4'h3, 4'h5);
        step();
        chk("wrong_fail", fail, 1);
        chk("wrong_unlock", unlocked, 0);
        wait_fail(1'b1, n);
        chk("fail_len", n, 8);
        chk("fail_cnt_after", digit_cnt, 0);
        chk("fail_state_locked", unlocked, 0);

        // clear beats a same-cycle digit.
        strobe(4'h1);
        strobe(4'h2);
        clear = 1'b1;
        digit_valid = 1'b1;
        digit = 4'h3;
        step();
        clear = 1'b0;
        digit_valid = 1'b0;
        chk("clear_cnt", digit_cnt, 0);
        enter4(4'h1, 4'h2, 4'h3, 4'h4);
        step();
        chk("clear_then_unlock", unlocked, 1);

        // Reprogram to 9876.
        prog = 1'b1;
        step();
        prog = 1'b0;
        chk("prog_active", prog_active, 1);
        chk("prog_unlocked", unlocked, 1);
        enter4(4'h9, 4'h8, 4'h7, 4'h6);
        chk("prog_done", prog_active, 0);
        chk("prog_still_unl", unlocked, 1);
        relock = 1'b1;
        step();
        relock = 1'b0;
        enter4(4'h1, 4'h2, 4'h3, 4'h4);
        step();
        chk("old_code_fails", fail, 1);
        wait_fail(1'b0, n);
        chk("old_fail_len", n, 8);
        enter4(4'h9, 4'h8, 4'h7, 4'h6);
        step();
        chk("new_code_unlocks", unlocked, 1);

        // rst restores the default code.
        rst = 1'b1;
        #1;
        chk("rst_async_unl", unlocked, 0);
        step();
        rst = 1'b0;
        enter4(4'h1, 4'h2, 4'h3, 4'h4);
        step();
        chk("rst_restores", unlocked, 1);

        // Reset mid-PROGRAM discards partial code.
        prog = 1'b1;
        step();
        prog = 1'b0;
        strobe(4'h9);
        strobe(4'h8);
        chk("midprog_cnt", digit_cnt, 2);
        rst = 1'b1;
        #1;
        chk("midprog_unl", unlocked, 0);
        chk("midprog_prog", prog_active, 0);
        chk("midprog_cnt0", digit_cnt, 0);
        chk("midprog_fail", fail, 0);
        step();
        rst = 1'b0;
        enter4(4'h1, 4'h2, 4'h3, 4'h4);
        step();
        chk("midprog_code", unlocked, 1);
        relock = 1'b1;
        step();
        relock = 1'b0;

        // Three consecutive wrong entries.
        for (int k = 0; k < 3; k++) begin
            enter4(4'h5, 4'h5, 4'h5, 4'h5);
            step();
            chk("trip_fail", fail, 1);
            wait_fail(1'b0, n);
            chk("trip_fail_len", n, 8);
        end
`ifdef COMBO_LOCKOUT_EN
        chk("lockout_on", locked_out, 1);
        m = 0;
        seen_unlock = 0;
        while (locked_out === 1'b1 && m < 2000) begin
            digit_valid = 1'b1;
            digit = 4'((m % 4) + 1);
            step();
            if (unlocked === 1'b1) seen_unlock = 1;
            m++;
        end
        digit_valid = 1'b0;
        chk("lockout_len", m, 1024);
        chk("lockout_ignores", seen_unlock, 0);
        chk("lockout_cnt", digit_cnt, 0);
`else
        chk("no_lockout", locked_out, 0);
`endif
        enter4(4'h1, 4'h2, 4'h3, 4'h4);
        step();
        chk("after_trip_unlock", unlocked, 1);
        chk("after_trip_lo", locked_out, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
